apply_writeback: RTL and testbench
==================================

APPLY_WRITEBACK -- requirements
Module: apply_writeback

Interface
REQ-001 The block SHALL have parameter data_width, default 64, meaning the vertex data width; the input word is data_width+1 bits.
REQ-002 The block SHALL have parameter addr_width, default 32, meaning the write address width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning write-buffer entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start_i, input, 1 bit: one-cycle pulse that begins an iteration.
REQ-007 The block SHALL have port base_addr_i, input, addr_width bits: address of vertex 0, captured on start.
REQ-008 The block SHALL have port num_vertices_i, input, 32 bits: item count for the iteration, captured on start.
REQ-009 The block SHALL have port valid_i, input, 1 bit: upstream apply result is valid.
REQ-010 The block SHALL have port data_i, input, data_width+1 bits: {vertex data, update flag}, with the flag in bit 0.
REQ-011 The block SHALL have port ready_o, output, 1 bit: the block accepts data_i this cycle.
REQ-012 The block SHALL have port wr_valid_o, output, 1 bit: a write request is presented.
REQ-013 The block SHALL have port wr_addr_o, output, addr_width bits: write address.
REQ-014 The block SHALL have port wr_data_o, output, data_width bits: write data.
REQ-015 The block SHALL have port wr_ready_i, input, 1 bit: memory accepts the write this cycle.
REQ-016 The block SHALL have port done_o, output, 1 bit: one-cycle pulse at the end of an iteration.
REQ-017 The block SHALL have port converged_o, output, 1 bit: the last iteration had zero flagged items; it holds until the next start.
REQ-018 The block SHALL have port update_count_o, output, 32 bits: number of flagged items in the current or last iteration.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE, start_i SHALL capture base and count, clear the vertex index and update_count_o, and go to RUN; if num_vertices_i==0 it SHALL go directly to DONE instead.
REQ-021 start_i SHALL be ignored in every state except IDLE.
REQ-022 ready_o SHALL equal (state==RUN) & ~fifo_full, with no same-cycle pop bypass.
REQ-023 An input SHALL transfer only when valid_i & ready_o; each transfer SHALL increment the vertex index by 1.
REQ-024 Each transfer SHALL form address base + index, as a modulo 2^addr_width sum that wraps silently.
REQ-025 Each transfer with flag set SHALL increment update_count_o.
REQ-026 The transfer that reaches index == num_vertices SHALL move the FSM RUN→DRAIN.
REQ-027 The FIFO head SHALL drive wr_valid_o/wr_addr_o/wr_data_o directly; an entry SHALL pop on wr_valid_o & wr_ready_i.
REQ-028 Push and pop SHALL be allowed in the same cycle.
REQ-029 Latency from an accepted input to the earliest wr_valid_o SHALL be 1 cycle.
REQ-030 wr_addr_o and wr_data_o SHALL remain stable while wr_valid_o=1 and wr_ready_i=0.
REQ-031 DRAIN→DONE SHALL occur when the FIFO is empty.
REQ-032 DONE SHALL last one cycle with done_o=1, latch converged_o = (update_count_o==0), and return to IDLE.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE, the FIFO SHALL be flushed (any in-flight write dropped), and ready_o, wr_valid_o, done_o and converged_o SHALL be 0.
REQ-034 On rst, update_count_o, wr_addr_o, wr_data_o and the index SHALL be 0.
REQ-035 Reset mid-iteration SHALL abort the iteration with no done_o pulse.

Configuration
REQ-036 With APPLY_FILTER_EN defined, only flagged items SHALL be pushed to the FIFO; unflagged items are consumed and dropped.
REQ-037 Without APPLY_FILTER_EN, every accepted item SHALL be pushed and written; flag counting is unchanged.

Structure
REQ-038 The shared package SHALL hold the wb_state_t enum and the wb_entry_t struct {addr, data}.
REQ-039 The FIFO SHALL be the sub-module wb_fifo (parameterised entry type/width and depth; full/empty/push/pop).

Verification
REQ-040 Filter on: base=0x100, N=4, flags 1,0,1,0, data 0xA..0xD, wr_ready=1 -> writes (0x100,0xA) and (0x102,0xC); update_count=2; done pulse; converged=0.
REQ-041 N=3, all flags 0 -> no writes under filter; done 1 cycle after the 3rd transfer plus drain; converged=1.
REQ-042 N=0 start -> DONE the next cycle; converged=1; ready_o never 1.
REQ-043 wr_ready=0 for 10 cycles, N=8, all flagged -> ready_o drops after 4 pushes; write address/data stable; all 8 writes complete in order after release.
REQ-044 base=0xFFFFFFFE, N=4, all flagged -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-045 rst asserted with 2 entries queued in DRAIN -> next cycle wr_valid=0, IDLE, no done pulse; a following start runs cleanly.

Source files
------------

// File: rtl/apply_writeback_pkg.sv
// rtl/apply_writeback_pkg.sv - shared state and write-buffer entry types for apply_writeback
package apply_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_t;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 64;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - write-buffer FIFO, head registered so it can drive the write port directly
module wb_fifo
  import apply_writeback_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/apply_writeback.sv
// rtl/apply_writeback.sv - vertex apply-result writeback; APPLY_FILTER_EN writes only flagged items
module apply_writeback
  import apply_writeback_pkg::*;
#(
  parameter int data_width = 64,
  parameter int addr_width = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [addr_width-1:0] base_addr_i,
  input  logic [31:0]           num_vertices_i,
  input  logic                  valid_i,
  input  logic [data_width:0]   data_i,
  output logic                  ready_o,
  output logic                  wr_valid_o,
  output logic [addr_width-1:0] wr_addr_o,
  output logic [data_width-1:0] wr_data_o,
  input  logic                  wr_ready_i,
  output logic                  done_o,
  output logic                  converged_o,
  output logic [31:0]           update_count_o
);

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] data;
  } entry_t;

  wb_state_t             state_q, state_d;
  logic [addr_width-1:0] base_q, base_d;
  logic [31:0]           num_q, num_d;
  logic [31:0]           idx_q, idx_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  conv_q, conv_d;
  logic                  done_q, done_d;

  logic   fifo_full, fifo_empty, xfer, flag, push, pop;
  entry_t push_entry, head;

  assign flag    = data_i[0];
  assign ready_o = (state_q == ST_RUN) & ~fifo_full;
  assign xfer    = valid_i & ready_o;

`ifdef APPLY_FILTER_EN
  assign push = xfer & flag;
`else
  assign push = xfer;
`endif

  assign push_entry.addr = base_q + addr_width'(idx_q);
  assign push_entry.data = data_i[data_width:1];

  assign wr_valid_o     = ~fifo_empty;
  assign pop            = wr_valid_o & wr_ready_i;
  // Head is masked while empty so the write bus reads zero out of reset.
  assign wr_addr_o      = fifo_empty ? '0 : head.addr;
  assign wr_data_o      = fifo_empty ? '0 : head.data;
  assign done_o         = done_q;
  assign converged_o    = conv_q;
  assign update_count_o = cnt_q;

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          num_d  = num_vertices_i;
          idx_d  = '0;
          cnt_d  = '0;
          conv_d = 1'b0;
          if (num_vertices_i == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            conv_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          idx_d = idx_q + 32'd1;
          if (flag) cnt_d = cnt_q + 32'd1;
          if (idx_q + 32'd1 == num_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          conv_d  = (cnt_q == 32'd0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      conv_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      conv_q  <= conv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_apply_writeback.sv
// tb/tb_apply_writeback.sv - randomized self-checking bench for apply_writeback against a queue model
module tb_apply_writeback;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
`ifdef APPLY_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [31:0]   num_vertices_i;
  logic          valid_i;
  logic [DW:0]   data_i;
  logic          ready_o;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_ready_i;
  logic          done_o;
  logic          converged_o;
  logic [31:0]   update_count_o;

  always #5 clk = ~clk;

  apply_writeback #(
    .data_width (DW),
    .addr_width (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .num_vertices_i (num_vertices_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .wr_valid_o     (wr_valid_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .wr_ready_i     (wr_ready_i),
    .done_o         (done_o),
    .converged_o    (converged_o),
    .update_count_o (update_count_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            phase;      // 0 idle, 1 run, 2 drain, 3 done
  int            k, n_cur, cnt;
  logic [AW-1:0] base_cur;
  bit            conv;
  int            vprob, rprob;
  bit            all_flag, no_flag, dir_en;
  bit            dir_flag [8];
  logic [DW-1:0] dir_data [8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    phase = 0; k = 0; n_cur = 0; cnt = 0; conv = 1'b0; base_cur = '0;
  endtask

  task automatic step(input bit s, input logic [AW-1:0] sb, input int sn);
    bit            fl, xfer;
    logic [DW-1:0] dv;
    int            qs;
    @(negedge clk);
    fl = all_flag ? 1'b1 : (no_flag ? 1'b0 : 1'($urandom_range(0, 1)));
    dv = {$urandom, $urandom};
    if (dir_en) begin
      fl = dir_flag[k % 8];
      dv = dir_data[k % 8];
    end
    start_i        = s;
    base_addr_i    = sb;
    num_vertices_i = sn;
    valid_i        = ($urandom_range(0, 99) < vprob);
    data_i         = {dv, fl};
    wr_ready_i     = ($urandom_range(0, 99) < rprob);
    #1;
    qs = exp_q.size();
    check("ready", ready_o, (phase == 1) && (qs < DEPTH));
    check("wr_valid", wr_valid_o, qs != 0);
    check("done", done_o, phase == 3);
    check("converged", converged_o, conv);
    check("update_count", update_count_o, cnt);
    if (wr_valid_o && qs != 0) begin
      check("wr_addr", wr_addr_o, exp_q[0].a);
      check("wr_data", wr_data_o, exp_q[0].d);
      if (wr_ready_i) void'(exp_q.pop_front());
    end
    xfer = valid_i && (phase == 1) && (qs < DEPTH);
    case (phase)
      0: if (s) begin
        base_cur = sb; n_cur = sn; k = 0; cnt = 0; conv = 1'b0;
        if (sn == 0) begin
          phase = 3;
          conv  = 1'b1;
        end else begin
          phase = 1;
        end
      end
      1: if (xfer) begin
        if (fl) cnt++;
        if (!FILT || fl) exp_q.push_back('{a: base_cur + AW'(k), d: dv});
        k++;
        if (k == n_cur) phase = 2;
      end
      2: if (qs == 0) begin
        phase = 3;
        conv  = (cnt == 0);
      end
      default: phase = 0;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0; valid_i = 1'b0; wr_ready_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready", ready_o, 1'b0);
    check("rst_wr_valid", wr_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_converged", converged_o, 1'b0);
    check("rst_update_count", update_count_o, 32'd0);
    check("rst_wr_addr", wr_addr_o, '0);
    check("rst_wr_data", wr_data_o, '0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run_iter(input logic [AW-1:0] b, input int n, input int vp,
                          input int rp, input int stall);
    bit s;
    vprob = vp;
    rprob = (stall > 0) ? 0 : rp;
    step(1'b1, b, n);
    for (int i = 0; i < 3000; i++) begin
      if (phase == 0) break;
      rprob = (i < stall) ? 0 : rp;
      s = (phase != 0) && ($urandom_range(0, 19) == 0);
      step(s, $urandom, $urandom_range(0, 7));
    end
    if (phase != 0) begin
      n_bad++;
      $display("FAIL iter_timeout: phase %0d expected 0", phase);
      do_reset();
    end
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; base_addr_i = '0; num_vertices_i = '0;
    valid_i = 1'b0; data_i = '0; wr_ready_i = 1'b0;
    all_flag = 1'b0; no_flag = 1'b0; dir_en = 1'b0;
    vprob = 100; rprob = 100;
    model_clear();
    do_reset();

    // flags 1,0,1,0 with data 0xA..0xD
    for (int i = 0; i < 8; i++) begin
      dir_flag[i] = (i % 2 == 0);
      dir_data[i] = DW'(10 + i);
    end
    dir_en = 1'b1;
    run_iter(32'h100, 4, 100, 100, 0);
    dir_en = 1'b0;

    no_flag = 1'b1;
    run_iter(32'h2000, 3, 100, 100, 0);
    no_flag = 1'b0;

    run_iter(32'h3000, 0, 100, 100, 0);

    all_flag = 1'b1;
    run_iter(32'h4000, 8, 100, 100, 10);
    run_iter(32'hFFFF_FFFE, 4, 100, 100, 0);

    // reset with two writes still queued in drain
    vprob = 100; rprob = 0;
    step(1'b1, 32'h5000, 2);
    for (int i = 0; i < 20 && !(phase == 2 && exp_q.size() == 2); i++) step(1'b0, '0, 0);
    check("drain_queued", exp_q.size(), 2);
    do_reset();
    run_iter(32'h6000, 5, 100, 100, 0);
    all_flag = 1'b0;

    for (int t = 0; t < 20; t++) begin
      run_iter($urandom, $urandom_range(1, 20), $urandom_range(30, 100),
               $urandom_range(30, 100), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
